// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer slice.
// Holds the sequencer state encoding, the redirect priority encodings,
// the default reset/exception vectors and the pending-buffer overwrite rule.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  localparam logic [1:0] PRIO_NONE = 2'd0;
  localparam logic [1:0] PRIO_JR   = 2'd1;
  localparam logic [1:0] PRIO_BR   = 2'd2;
  localparam logic [1:0] PRIO_EXC  = 2'd3;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;
  localparam logic [31:0] PC_STEP_DEF      = 32'd4;

  // A newer redirect replaces a buffered one on equal or higher priority,
  // so the most recent of two same-class redirects is the one honoured.
  function automatic logic prio_overrides(input logic [1:0] new_prio,
                                          input logic [1:0] held_prio);
    return (new_prio >= held_prio);
  endfunction

endpackage

// File: rtl/fetch_sequencer_redirect_arbiter.sv
// Combinational redirect arbiter.
// Picks the highest-priority redirect among exception, taken branch and
// jump-register, and decides how it interacts with the pending buffer.
// Ports:
//   exception/branch_taken/jump_reg + targets : raw redirect sources
//   pend_valid/pend_prio/pend_tgt             : current pending buffer
//   redir_now/redir_prio/redir_tgt            : this-cycle winner
//   pend_load                                 : winner should overwrite buffer
//   win_valid/win_tgt                         : pending-vs-now winner
module redirect_arbiter
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_target,
  input  logic        pend_valid,
  input  logic [1:0]  pend_prio,
  input  logic [31:0] pend_tgt,
  output logic        redir_now,
  output logic [1:0]  redir_prio,
  output logic [31:0] redir_tgt,
  output logic        pend_load,
  output logic        win_valid,
  output logic [31:0] win_tgt
);

  // Fixed-priority select of the redirect source for this cycle.
  always_comb begin
    redir_prio = PRIO_NONE;
    redir_tgt  = 32'h0000_0000;
    if (exception) begin
      redir_prio = PRIO_EXC;
      redir_tgt  = EXC_VECTOR;
    end else if (branch_taken) begin
      redir_prio = PRIO_BR;
      redir_tgt  = branch_target;
    end else if (jump_reg) begin
      redir_prio = PRIO_JR;
      redir_tgt  = jump_target;
    end else begin
      redir_prio = PRIO_NONE;
      redir_tgt  = 32'h0000_0000;
    end
  end

  assign redir_now = (redir_prio != PRIO_NONE);

  // An empty buffer holds PRIO_NONE, so any real redirect overrides it.
  assign pend_load = redir_now && prio_overrides(redir_prio, pend_prio);
  assign win_valid = redir_now || pend_valid;
  assign win_tgt   = pend_load ? redir_tgt : pend_tgt;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and sequences instruction fetch against a
// ready-handshaked instruction memory, with redirect arbitration, stall
// handling and a one-deep pending-redirect buffer for redirects that
// arrive while a fetch is outstanding.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   stall                     : decode cannot accept an instruction
//   exception/branch_taken/jump_reg (+targets) : redirect sources
//   imem_ready                : memory completes the current request
//   imem_req/imem_addr        : fetch request and address (= pc)
//   pc                        : PC register
//   inst_valid                : returned instruction is good for decode
//   flush                     : kill IF/ID this cycle
//   redirect_pending          : pending buffer occupied
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        flush,
  output logic        redirect_pending
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic         pend_valid_r, pend_valid_nxt_s;
  logic [1:0]   pend_prio_r, pend_prio_nxt_s;
  logic [31:0]  pend_tgt_r, pend_tgt_nxt_s;

  logic         redir_now_s, pend_load_s, win_valid_s;
  logic [1:0]   redir_prio_s;
  logic [31:0]  redir_tgt_s, win_tgt_s;

  redirect_arbiter #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
    .exception    (exception),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_reg     (jump_reg),
    .jump_target  (jump_target),
    .pend_valid   (pend_valid_r),
    .pend_prio    (pend_prio_r),
    .pend_tgt     (pend_tgt_r),
    .redir_now    (redir_now_s),
    .redir_prio   (redir_prio_s),
    .redir_tgt    (redir_tgt_s),
    .pend_load    (pend_load_s),
    .win_valid    (win_valid_s),
    .win_tgt      (win_tgt_s)
  );

  // Next-state, next-PC, pending-buffer update and handshake outputs.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_prio_nxt_s  = pend_prio_r;
    pend_tgt_nxt_s   = pend_tgt_r;
    imem_req         = 1'b0;
    inst_valid       = 1'b0;
    flush            = 1'b0;
    case (state_r)
      ST_BOOT: begin
        // No flush out of BOOT: IF/ID holds nothing yet.
        if (redir_now_s) begin
          pc_nxt_s = redir_tgt_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        flush = redir_now_s;
        if (stall) begin
          // No request is issued, so a redirect can go straight to pc.
          if (redir_now_s) begin
            pc_nxt_s = redir_tgt_s;
          end else begin
            pc_nxt_s = pc_r;
          end
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            inst_valid = !redir_now_s;
            pc_nxt_s   = redir_now_s ? redir_tgt_s : (pc_r + PC_STEP);
          end else begin
            // Address must stay stable while the request is open.
            if (pend_load_s) begin
              pend_valid_nxt_s = 1'b1;
              pend_prio_nxt_s  = redir_prio_s;
              pend_tgt_nxt_s   = redir_tgt_s;
            end else begin
              pend_valid_nxt_s = pend_valid_r;
            end
            state_nxt_s = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Request stays up regardless of stall until memory completes.
        flush    = redir_now_s;
        imem_req = 1'b1;
        if (imem_ready) begin
          pend_valid_nxt_s = 1'b0;
          pend_prio_nxt_s  = PRIO_NONE;
          pend_tgt_nxt_s   = 32'h0000_0000;
          state_nxt_s      = ST_FETCH;
          if (win_valid_s) begin
            pc_nxt_s = win_tgt_s;
          end else if (stall) begin
            // Decode can't take it: drop and refetch the same address.
            pc_nxt_s = pc_r;
          end else begin
            inst_valid = 1'b1;
            pc_nxt_s   = pc_r + PC_STEP;
          end
        end else begin
          if (pend_load_s) begin
            pend_valid_nxt_s = 1'b1;
            pend_prio_nxt_s  = redir_prio_s;
            pend_tgt_nxt_s   = redir_tgt_s;
          end else begin
            pend_valid_nxt_s = pend_valid_r;
          end
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // State, PC and pending-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_VECTOR;
      pend_valid_r <= 1'b0;
      pend_prio_r  <= PRIO_NONE;
      pend_tgt_r   <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_prio_r  <= pend_prio_nxt_s;
      pend_tgt_r   <= pend_tgt_nxt_s;
    end
  end

  assign imem_addr        = pc_r;
  assign pc               = pc_r;
  assign redirect_pending = pend_valid_r;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Front-end controller that owns the program counter and sequences instruction fetch against a handshaked instruction memory.
It arbitrates redirect sources (exception, taken branch, jump-register) against sequential fetch, stalls from the hazard unit, and memory wait states.
It holds a one-deep pending-redirect buffer for redirects that arrive while a fetch is outstanding, and generates the IF/ID flush and instruction-valid qualifiers.
It sits between the hazard/branch logic in EX/ID and the instruction memory port.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset
EXC_VECTOR, 32'h0000_0080, redirect target on exception
PC_STEP, 32'd4, sequential increment

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: decode cannot accept an instruction
exception  in  1  redirect to EXC_VECTOR (priority 3)
branch_taken  in  1  redirect to branch_target (priority 2)
branch_target  in  32  branch destination
jump_reg  in  1  redirect to jump_target (priority 1)
jump_target  in  32  jump destination
imem_ready  in  1  instruction memory completes current request this cycle
imem_req  out  1  fetch request; imem_addr valid while high
imem_addr  out  32  fetch address (= registered pc)
pc  out  32  current PC register
inst_valid  out  1  instruction returned this cycle is good for decode
flush  out  1  kill IF/ID contents this cycle
redirect_pending  out  1  pending-redirect buffer occupied

Behaviour:
- Reset, asynchronous: pc=RESET_VECTOR, state=BOOT, pending cleared; imem_req=0, inst_valid=0, flush=0, redirect_pending=0.
- Reset mid-fetch abandons the outstanding request. No handshake completion is owed.
- Redirect arbitration is combinational: exception > branch_taken > jump_reg. redir_now = any source high; redir_tgt = target of the winner.
- Pending buffer: pend_valid, pend_prio (2 bits), pend_tgt (32 bits).
  - A new redirect overwrites the buffer only if its priority is >= pend_prio.
  - A lower-priority redirect is ignored but still asserts flush.
- flush = redir_now, registered-free (same cycle as the request), in every state except BOOT.
- States:
  - BOOT: imem_req=0; applies redir_now to pc if present. Next state: FETCH.
  - FETCH, stall=1: imem_req=0; pc held; redir_now loads pc<=redir_tgt directly. Stay in FETCH.
  - FETCH, stall=0: imem_req=1, imem_addr=pc.
    - imem_ready=1: inst_valid=!redir_now. pc<=redir_now ? redir_tgt : pc+PC_STEP. Stay in FETCH.
    - imem_ready=0: redir_now is latched into pending. Go to WAIT.
  - WAIT: imem_req=1 regardless of stall; imem_addr stable (pc unchanged). Redirects are latched into pending.
    - imem_ready=1: the winner between pending and redir_now (by priority) loads pc; inst_valid=0; pending cleared. Go to FETCH.
    - imem_ready=1, no redirect, stall=1: inst_valid=0; pc unchanged, so the same address is refetched. Go to FETCH.
    - imem_ready=1, no redirect, stall=0: inst_valid=1; pc<=pc+PC_STEP. Go to FETCH.
- Latency: a redirect in FETCH reaches imem_addr the next cycle. In WAIT, it reaches imem_addr the cycle after completion.
- Arithmetic: pc+PC_STEP is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Targets are used unmodified; no alignment check.
- inst_valid is never high when flush is high.

Decomposition:
- Shared package (fetch_pkg) holds:
  - state encoding: BOOT=2'd0, FETCH=2'd1, WAIT=2'd2
  - priority encodings: EXC=3, BR=2, JR=1, NONE=0
  - the RESET_VECTOR/EXC_VECTOR defaults
- One natural sub-module, redirect_arbiter: combinational priority select of {prio, target}, plus the compare/overwrite decision for the pending buffer.

Test Plan:
- Reset release, imem_ready=1 constant, no events -> BOOT one cycle, then imem_addr 0,4,8,12 on consecutive cycles with inst_valid=1.
- pc=0x10 in FETCH, branch_taken=1 with branch_target=0x200 for one cycle -> flush=1, inst_valid=0 that cycle; next imem_addr=0x200.
- imem_ready=0 for 3 cycles at pc=0x20; jump_reg (0x300) in cycle 1, exception in cycle 2 -> pend_prio=3; on completion pc=0x80, inst_valid=0; a later lower-priority jump_reg before completion is ignored.
- stall=1 for 2 cycles in FETCH at pc=0x40 -> imem_req=0, pc=0x40 held; stall=0 -> fetch 0x40, then 0x44.
- WAIT completes with stall=1 at pc=0x50 -> inst_valid=0, next fetch refetches 0x50.
- Set pc near 0xFFFF_FFF8 via branch, free-run -> 0xFFFF_FFFC then 0x0. Assert rst during WAIT -> pc=RESET_VECTOR, imem_req=0, redirect_pending=0 asynchronously.
